// File: rtl/rs_pkg.sv
// Shared types and constants for the mul/div reservation station.
package rs_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned AGE_W  = 4;

  localparam logic [CTRL_W-1:0] CTRL_MUL = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_DIV = 4'b0011;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } ent_state_t;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_BUSY  = 2'd1,
    D_DRAIN = 2'd2
  } disp_state_t;

  typedef struct packed {
    ent_state_t        state;
    logic [AGE_W-1:0]  age;
    logic [CTRL_W-1:0] ctrl;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic              qj_v;
    logic              qk_v;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest ready entry using wrap-aware age comparison.
module rs_oldest_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned AGE_W = 4
) (
  input  logic [N-1:0]       ready,
  input  logic [N*AGE_W-1:0] ages,
  output logic [N-1:0]       grant,
  output logic               valid
);

  logic             win;
  logic [AGE_W-1:0] diff;

  // Entry i wins if no other ready entry is older (ties broken by lower index).
  always_comb begin
    grant = '0;
    win   = 1'b0;
    diff  = '0;
    for (int i = 0; i < N; i++) begin
      win = ready[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && ready[j]) begin
          diff = ages[j*AGE_W +: AGE_W] - ages[i*AGE_W +: AGE_W];
          if (diff[AGE_W-1]) win = 1'b0;
          else if (diff == '0 && j < i) win = 1'b0;
        end
      end
      grant[i] = win;
    end
  end

  assign valid = |ready;

endmodule

// File: rtl/mul_div_rs.sv
// Reservation station feeding a single multi-cycle mul/div unit.
module mul_div_rs
  import rs_pkg::*;
#(
  parameter int unsigned      ENTRIES = 4,
  parameter logic [TAG_W-1:0] RS_BASE = 5'd8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [CTRL_W-1:0] issue_ctrl,
  input  logic [TAG_W-1:0]  issue_rob,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_qj_valid,
  input  logic              issue_qk_valid,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_rob,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              fu_data_ready,
  output logic [DATA_W-1:0] fu_x,
  output logic [DATA_W-1:0] fu_y,
  output logic [CTRL_W-1:0] fu_ctrl,
  output logic [TAG_W-1:0]  fu_save_no,
  output logic [TAG_W-1:0]  fu_rd_rob,
  input  logic              fu_done,
  input  logic [TAG_W-1:0]  fu_save_no_in,
  input  logic              flush,
  output logic              illegal_issue,
  output logic [3:0]        busy_count
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  rs_entry_t            ent_q [ENTRIES];
  rs_entry_t            ent_d [ENTRIES];
  disp_state_t          disp_q, disp_d;
  logic [AGE_W-1:0]     age_ctr;
  logic [IDX_W-1:0]     exec_idx;
  logic [ENTRIES-1:0]   free_vec, ready_vec, grant;
  logic [ENTRIES*AGE_W-1:0] ages;
  logic                 grant_valid;
  logic [IDX_W-1:0]     alloc_idx, gnt_idx;
  logic                 issue_fire, issue_legal, alloc, dispatch, done_match;
  logic [3:0]           cnt_d;

  // Per-entry status vectors, first free slot and granted index.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    ages      = '0;
    alloc_idx = '0;
    gnt_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      free_vec[i]  = (ent_q[i].state == ST_FREE);
      ready_vec[i] = (ent_q[i].state == ST_READY);
      ages[i*AGE_W +: AGE_W] = ent_q[i].age;
      if (free_vec[i]) alloc_idx = IDX_W'(i);
      if (grant[i]) gnt_idx = IDX_W'(i);
    end
  end

  rs_oldest_select #(.N(ENTRIES), .AGE_W(AGE_W)) u_select (
    .ready (ready_vec),
    .ages  (ages),
    .grant (grant),
    .valid (grant_valid)
  );

  assign issue_ready = (|free_vec) && (disp_q != D_DRAIN);
  assign issue_fire  = issue_valid && issue_ready && !flush;
  assign issue_legal = (issue_ctrl == CTRL_MUL) || (issue_ctrl == CTRL_DIV);
  assign alloc       = issue_fire && issue_legal;
  assign dispatch    = (disp_q == D_IDLE) && grant_valid && !flush;
  assign done_match  = fu_done && (fu_save_no_in == fu_save_no) &&
                       (disp_q != D_IDLE);

  // Dispatch FSM next state.
  always_comb begin
    disp_d = disp_q;
    case (disp_q)
      D_IDLE:  if (dispatch) disp_d = D_BUSY;
      D_BUSY:  if (done_match) disp_d = D_IDLE;
               else if (flush) disp_d = D_DRAIN;
      D_DRAIN: if (done_match) disp_d = D_IDLE;
      default: disp_d = D_IDLE;
    endcase
  end

  // Entry next state: CDB capture, wake-up, dispatch, retire, flush, allocate.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].state == ST_WAIT) begin
        if (cdb_valid && ent_q[i].qj_v && ent_q[i].qj == cdb_rob) begin
          ent_d[i].vj   = cdb_value;
          ent_d[i].qj_v = 1'b0;
        end
        if (cdb_valid && ent_q[i].qk_v && ent_q[i].qk == cdb_rob) begin
          ent_d[i].vk   = cdb_value;
          ent_d[i].qk_v = 1'b0;
        end
        if (!ent_q[i].qj_v && !ent_q[i].qk_v) ent_d[i].state = ST_READY;
      end
      if (dispatch && grant[i]) ent_d[i].state = ST_EXEC;
      if (done_match && exec_idx == IDX_W'(i)) ent_d[i].state = ST_FREE;
      if (flush && ent_q[i].state != ST_EXEC) ent_d[i].state = ST_FREE;
      if (alloc && alloc_idx == IDX_W'(i)) begin
        ent_d[i].age  = age_ctr;
        ent_d[i].ctrl = issue_ctrl;
        ent_d[i].rob  = issue_rob;
        ent_d[i].qj   = issue_qj;
        ent_d[i].qk   = issue_qk;
        ent_d[i].qj_v = issue_qj_valid && !(cdb_valid && cdb_rob == issue_qj);
        ent_d[i].qk_v = issue_qk_valid && !(cdb_valid && cdb_rob == issue_qk);
        ent_d[i].vj   = (issue_qj_valid && cdb_valid && cdb_rob == issue_qj) ?
                        cdb_value : issue_vj;
        ent_d[i].vk   = (issue_qk_valid && cdb_valid && cdb_rob == issue_qk) ?
                        cdb_value : issue_vk;
        ent_d[i].state = (ent_d[i].qj_v || ent_d[i].qk_v) ? ST_WAIT : ST_READY;
      end
      if (ent_d[i].state != ST_FREE) cnt_d = cnt_d + 4'd1;
    end
  end

  // State, counters and registered unit interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      disp_q        <= D_IDLE;
      age_ctr       <= '0;
      exec_idx      <= '0;
      fu_data_ready <= 1'b0;
      fu_x          <= '0;
      fu_y          <= '0;
      fu_ctrl       <= '0;
      fu_save_no    <= '0;
      fu_rd_rob     <= '0;
      illegal_issue <= 1'b0;
      busy_count    <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
      disp_q        <= disp_d;
      busy_count    <= cnt_d;
      illegal_issue <= issue_fire && !issue_legal;
      fu_data_ready <= dispatch;
      if (alloc) age_ctr <= age_ctr + AGE_W'(1);
      if (dispatch) begin
        exec_idx   <= gnt_idx;
        fu_x       <= ent_q[gnt_idx].vj;
        fu_y       <= ent_q[gnt_idx].vk;
        fu_ctrl    <= ent_q[gnt_idx].ctrl;
        fu_rd_rob  <= ent_q[gnt_idx].rob;
        fu_save_no <= RS_BASE + TAG_W'(gnt_idx);
      end
    end
  end

endmodule

// File: tb/tb_mul_div_rs.sv
// Directed self-checking bench for mul_div_rs.
module tb_mul_div_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_ctrl;
  logic [4:0]  issue_rob;
  logic [31:0] issue_vj, issue_vk;
  logic        issue_qj_valid, issue_qk_valid;
  logic [4:0]  issue_qj, issue_qk;
  logic        cdb_valid;
  logic [4:0]  cdb_rob;
  logic [31:0] cdb_value;
  logic        fu_data_ready;
  logic [31:0] fu_x, fu_y;
  logic [3:0]  fu_ctrl;
  logic [4:0]  fu_save_no, fu_rd_rob;
  logic        fu_done;
  logic [4:0]  fu_save_no_in;
  logic        flush, illegal_issue;
  logic [3:0]  busy_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_div_rs dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_ctrl(issue_ctrl), .issue_rob(issue_rob),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .fu_data_ready(fu_data_ready), .fu_x(fu_x), .fu_y(fu_y),
    .fu_ctrl(fu_ctrl), .fu_save_no(fu_save_no), .fu_rd_rob(fu_rd_rob),
    .fu_done(fu_done), .fu_save_no_in(fu_save_no_in),
    .flush(flush), .illegal_issue(illegal_issue), .busy_count(busy_count)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_issue(input logic [3:0] ctrl, input logic [31:0] vj, input logic [31:0] vk,
                          input logic qjv, input logic [4:0] qj,
                          input logic qkv, input logic [4:0] qk, input logic [4:0] rob);
    issue_valid = 1'b1; issue_ctrl = ctrl; issue_vj = vj; issue_vk = vk;
    issue_qj_valid = qjv; issue_qj = qj; issue_qk_valid = qkv; issue_qk = qk;
    issue_rob = rob;
    step();
    issue_valid = 1'b0; issue_qj_valid = 1'b0; issue_qk_valid = 1'b0;
  endtask

  task automatic retire(input logic [4:0] tag);
    fu_done = 1'b1; fu_save_no_in = tag;
    step();
    fu_done = 1'b0;
  endtask

  task automatic wait_dispatch(input string name);
    int n = 0;
    while (!fu_data_ready && n < 20) begin
      step();
      n++;
    end
    total++;
    if (fu_data_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: dispatch timeout, fu_data_ready=%b required 1", name, fu_data_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    total++;
    if ({fu_data_ready, fu_x, fu_y, fu_ctrl, fu_save_no, fu_rd_rob, illegal_issue, busy_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: dr=%b x=%0d y=%0d ctrl=%0d sn=%0d rob=%0d ill=%b bc=%0d required all 0",
               fu_data_ready, fu_x, fu_y, fu_ctrl, fu_save_no, fu_rd_rob, illegal_issue, busy_count);
    end
    total++;
    if (issue_ready !== 1'b1) begin
      bad++; $display("FAIL reset_issue_ready: got %b required 1", issue_ready);
    end
  endtask

  task automatic test_mul_basic();
    do_issue(4'b0010, 32'd6, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd12);
    total++;
    if (fu_data_ready !== 1'b0 || busy_count !== 4'd1) begin
      bad++; $display("FAIL mul_cycle1: dr=%b bc=%0d required 0/1", fu_data_ready, busy_count);
    end
    step();
    total++;
    if (fu_data_ready !== 1'b1 || fu_x !== 32'd6 || fu_y !== 32'd7 || fu_ctrl !== 4'd2 ||
        fu_save_no !== 5'd8 || fu_rd_rob !== 5'd12) begin
      bad++;
      $display("FAIL mul_dispatch: dr=%b x=%0d y=%0d ctrl=%0d sn=%0d rob=%0d required 1/6/7/2/8/12",
               fu_data_ready, fu_x, fu_y, fu_ctrl, fu_save_no, fu_rd_rob);
    end
    step();
    total++;
    if (fu_data_ready !== 1'b0 || fu_x !== 32'd6 || busy_count !== 4'd1) begin
      bad++; $display("FAIL mul_hold: dr=%b x=%0d bc=%0d required 0/6/1", fu_data_ready, fu_x, busy_count);
    end
    retire(5'd8);
    total++;
    if (busy_count !== 4'd0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL mul_retire: bc=%0d ir=%b required 0/1", busy_count, issue_ready);
    end
  endtask

  task automatic test_operand_wait();
    do_issue(4'b0011, 32'd0, 32'd5, 1'b1, 5'd3, 1'b0, 5'd0, 5'd4);
    step(); step();
    total++;
    if (fu_data_ready !== 1'b0 || busy_count !== 4'd1) begin
      bad++; $display("FAIL wait_no_dispatch: dr=%b bc=%0d required 0/1", fu_data_ready, busy_count);
    end
    cdb_valid = 1'b1; cdb_rob = 5'd3; cdb_value = 32'd100;
    step();
    cdb_valid = 1'b0;
    wait_dispatch("wait_dispatch");
    total++;
    if (fu_x !== 32'd100 || fu_y !== 32'd5 || fu_ctrl !== 4'd3 || fu_save_no !== 5'd8) begin
      bad++; $display("FAIL wait_operands: x=%0d y=%0d ctrl=%0d sn=%0d required 100/5/3/8",
                      fu_x, fu_y, fu_ctrl, fu_save_no);
    end
    step();
    retire(5'd8);
  endtask

  task automatic test_bypass();
    cdb_valid = 1'b1; cdb_rob = 5'd3; cdb_value = 32'd100;
    do_issue(4'b0011, 32'd0, 32'd9, 1'b1, 5'd3, 1'b0, 5'd0, 5'd5);
    cdb_valid = 1'b0;
    step();
    total++;
    if (fu_data_ready !== 1'b1 || fu_x !== 32'd100 || fu_y !== 32'd9) begin
      bad++; $display("FAIL bypass: dr=%b x=%0d y=%0d required 1/100/9", fu_data_ready, fu_x, fu_y);
    end
    step();
    retire(5'd8);
  endtask

  task automatic test_wrong_tag();
    do_issue(4'b0010, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 5'd0, 5'd6);
    wait_dispatch("wrong_tag_dispatch");
    step();
    retire(5'd9);
    total++;
    if (busy_count !== 4'd1) begin
      bad++; $display("FAIL wrong_tag_ignored: bc=%0d required 1", busy_count);
    end
    do_issue(4'b0010, 32'd11, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    step(); step();
    total++;
    if (fu_data_ready !== 1'b0 || fu_save_no !== 5'd8 || busy_count !== 4'd2) begin
      bad++; $display("FAIL wrong_tag_busy: dr=%b sn=%0d bc=%0d required 0/8/2",
                      fu_data_ready, fu_save_no, busy_count);
    end
    retire(5'd8);
    wait_dispatch("wrong_tag_second");
    total++;
    if (fu_save_no !== 5'd9 || fu_x !== 32'd11) begin
      bad++; $display("FAIL wrong_tag_next: sn=%0d x=%0d required 9/11", fu_save_no, fu_x);
    end
    step();
    retire(5'd9);
  endtask

  task automatic test_flush_busy();
    do_issue(4'b0010, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
    wait_dispatch("flush_dispatch");
    do_issue(4'b0010, 32'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd2);
    do_issue(4'b0011, 32'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd3);
    total++;
    if (busy_count !== 4'd3) begin
      bad++; $display("FAIL flush_pre: bc=%0d required 3", busy_count);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (busy_count !== 4'd1 || issue_ready !== 1'b0) begin
      bad++; $display("FAIL flush_drain: bc=%0d ir=%b required 1/0", busy_count, issue_ready);
    end
    step();
    total++;
    if (issue_ready !== 1'b0) begin
      bad++; $display("FAIL flush_hold: ir=%b required 0", issue_ready);
    end
    retire(5'd8);
    step();
    total++;
    if (busy_count !== 4'd0 || issue_ready !== 1'b1 || fu_data_ready !== 1'b0) begin
      bad++; $display("FAIL flush_done: bc=%0d ir=%b dr=%b required 0/1/0",
                      busy_count, issue_ready, fu_data_ready);
    end
  endtask

  task automatic test_illegal();
    do_issue(4'b0101, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
    total++;
    if (illegal_issue !== 1'b1 || busy_count !== 4'd0) begin
      bad++; $display("FAIL illegal_pulse: ill=%b bc=%0d required 1/0", illegal_issue, busy_count);
    end
    step();
    total++;
    if (illegal_issue !== 1'b0) begin
      bad++; $display("FAIL illegal_one_cycle: ill=%b required 0", illegal_issue);
    end
  endtask

  task automatic test_rst_mid_busy();
    do_issue(4'b0010, 32'd6, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd2);
    wait_dispatch("rst_dispatch");
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({fu_data_ready, fu_x, fu_y, fu_ctrl, fu_save_no, fu_rd_rob, illegal_issue, busy_count} !== '0 ||
        issue_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_busy: dr=%b x=%0d sn=%0d bc=%0d ir=%b required 0/0/0/0/1",
                      fu_data_ready, fu_x, fu_save_no, busy_count, issue_ready);
    end
    retire(5'd8);
    do_issue(4'b0010, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    wait_dispatch("rst_after_dispatch");
    total++;
    if (fu_save_no !== 5'd8 || fu_x !== 32'd9) begin
      bad++; $display("FAIL rst_after: sn=%0d x=%0d required 8/9", fu_save_no, fu_x);
    end
    step();
    retire(5'd8);
  endtask

  task automatic test_fill_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      do_issue(4'b0010, 32'(i + 40), 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
      wait_dispatch("warmup_dispatch");
      total++;
      if (fu_x !== 32'(i + 40)) begin
        bad++; $display("FAIL warmup_%0d: x=%0d required %0d", i, fu_x, i + 40);
      end
      step();
      retire(5'd8);
    end
    for (int k = 0; k < 4; k++)
      do_issue(4'b0011, 32'(10 + k), 32'd0, 1'b0, 5'd0, 1'b1, 5'd20, 5'(k));
    total++;
    if (issue_ready !== 1'b0 || busy_count !== 4'd4) begin
      bad++; $display("FAIL fill_full: ir=%b bc=%0d required 0/4", issue_ready, busy_count);
    end
    do_issue(4'b0010, 32'd99, 32'd99, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
    total++;
    if (busy_count !== 4'd4) begin
      bad++; $display("FAIL fill_fifth: bc=%0d required 4", busy_count);
    end
    cdb_valid = 1'b1; cdb_rob = 5'd20; cdb_value = 32'd1;
    step();
    cdb_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_dispatch("fill_dispatch");
      total++;
      if (fu_x !== 32'(10 + k) || fu_y !== 32'd1 || fu_save_no !== 5'(8 + k)) begin
        bad++; $display("FAIL fill_order_%0d: x=%0d y=%0d sn=%0d required %0d/1/%0d",
                        k, fu_x, fu_y, fu_save_no, 10 + k, 8 + k);
      end
      step();
      retire(5'(8 + k));
    end
    total++;
    if (busy_count !== 4'd0) begin
      bad++; $display("FAIL fill_empty: bc=%0d required 0", busy_count);
    end
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_ctrl = '0; issue_rob = '0;
    issue_vj = '0; issue_vk = '0; issue_qj_valid = 1'b0; issue_qk_valid = 1'b0;
    issue_qj = '0; issue_qk = '0; cdb_valid = 1'b0; cdb_rob = '0; cdb_value = '0;
    fu_done = 1'b0; fu_save_no_in = '0; flush = 1'b0;
    step();
    test_reset();
    test_mul_basic();
    test_operand_wait();
    test_bypass();
    test_wrong_tag();
    test_flush_busy();
    test_illegal();
    test_rst_mid_busy();
    test_fill_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_rs.md
MUL_DIV_RS -- requirements
Module: mul_div_rs

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of reservation-station entries (2..8).
REQ-002 SHALL have parameter RS_BASE, default 5'd8, save_no of entry 0; entry i uses RS_BASE+i.
REQ-003 SHALL have ports, one per line:
  clk  in  1  sole clock, rising edge
  rst  in  1  reset, synchronous, active-high
  issue_valid  in  1  issue request
  issue_ready  out  1  at least one FREE entry and not flushing
  issue_ctrl  in  4  op: 4'b0010 mul, 4'b0011 div
  issue_rob  in  5  destination ROB tag
  issue_vj, issue_vk  in  32 each  operand values
  issue_qj_valid, issue_qk_valid  in  1 each  operand still pending
  issue_qj, issue_qk  in  5 each  producing ROB tag when pending
  cdb_valid  in  1  result broadcast valid
  cdb_rob  in  5  broadcast ROB tag
  cdb_value  in  32  broadcast value
  fu_data_ready  out  1  one-cycle dispatch pulse to mul/div unit
  fu_x, fu_y  out  32 each  operands A/B
  fu_ctrl  out  4  function select
  fu_save_no  out  5  dispatched entry's save_no
  fu_rd_rob  out  5  dispatched entry's ROB tag
  fu_done  in  1  unit completion
  fu_save_no_in  in  5  save_no returned with fu_done
  flush  in  1  discard all entries (mispredict)
  illegal_issue  out  1  pulse: issue with unsupported ctrl
  busy_count  out  4  number of non-FREE entries

Function
REQ-004 Each entry SHALL be in one of FREE, WAIT (an operand pending), READY, EXEC.
REQ-005 Issue SHALL be accepted at the edge where issue_valid && issue_ready; the lowest-index FREE entry is allocated; age stamp = current 4-bit issue counter, which then increments (wraps mod 16, compared via wrap-aware subtraction).
REQ-006 Issue with ctrl other than 4'b0010/4'b0011 SHALL allocate nothing and pulse illegal_issue one cycle later.
REQ-007 On cdb_valid, every WAIT entry with a pending tag equal to cdb_rob SHALL capture cdb_value and clear that pending bit; an issuing op whose qj/qk matches cdb_rob in the same cycle SHALL capture cdb_value (bypass).
REQ-008 An entry with no pending operand SHALL be READY at the following edge.
REQ-009 Dispatch FSM SHALL have states IDLE, BUSY, DRAIN; reset state IDLE.
REQ-010 In IDLE with any READY entry, the oldest READY entry SHALL be selected; at that edge the entry goes EXEC, fu_x/fu_y/fu_ctrl/fu_save_no/fu_rd_rob are registered, fu_data_ready is high for exactly the next cycle, FSM goes BUSY.
REQ-011 Minimum latency issue-with-both-operands to fu_data_ready high SHALL be 2 cycles.
REQ-012 fu_* outputs SHALL hold stable from dispatch until fu_done is accepted.
REQ-013 In BUSY, fu_done with fu_save_no_in equal to fu_save_no SHALL free that entry and return FSM to IDLE; fu_done with any other tag SHALL be ignored.
REQ-014 A freed entry SHALL NOT be reallocated in the same cycle it is freed (issue_ready derived from registered state).
REQ-015 flush SHALL free all non-EXEC entries at the edge; if BUSY, FSM goes DRAIN, issue_ready = 0, and the in-flight result is discarded on matching fu_done (entry freed, FSM IDLE).
REQ-016 flush and issue in the same cycle: flush wins, issue not accepted.
REQ-017 busy_count SHALL equal the number of non-FREE entries, registered.

Reset
REQ-018 rst at an edge SHALL set all entries FREE, FSM IDLE, issue counter 0, and fu_data_ready, fu_x, fu_y, fu_ctrl, fu_save_no, fu_rd_rob, illegal_issue, busy_count to 0; issue_ready = 1 the cycle after.
REQ-019 rst mid-operation SHALL abandon any in-flight op; a later fu_done SHALL be ignored.

Structure
REQ-020 Shared package rs_pkg SHALL hold DATA_W=32, TAG_W=5, CTRL_MUL=4'b0010, CTRL_DIV=4'b0011 and the entry-state enumeration.
REQ-021 Oldest-ready selection SHALL be a sub-module rs_oldest_select (ready vector + age stamps in, one-hot grant + valid out).

Verification
REQ-022 Issue mul vj=6 vk=7 no pending -> fu_data_ready 2 cycles later, fu_x=6, fu_y=7, fu_ctrl=2, fu_save_no=8; fu_done tag 8 -> busy_count 1->0.
REQ-023 Issue div with qj=3 pending, then cdb_rob=3 value 100 -> fu_x=100 on dispatch; repeat with CDB in issue cycle -> bypass captures 100.
REQ-024 Fill 4 entries -> issue_ready=0, fifth issue ignored; all READY -> dispatched in issue order across a counter wrap.
REQ-025 fu_done with tag 9 while entry 8 in flight -> ignored, FSM stays BUSY.
REQ-026 flush while BUSY with 3 entries -> busy_count=1, issue_ready=0 until fu_done tag matches, then IDLE, busy_count=0.
REQ-027 Issue ctrl=4'b0101 -> illegal_issue pulse, busy_count unchanged; rst mid-BUSY -> all outputs 0.
